// File: rtl/mem_bus_ctrl_if.sv
// Request/acknowledge and memory-side control signals of mem_bus_ctrl.
// The shared tri-state data bus stays a plain inout port on the controller.
interface mem_bus_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          busy;
  logic          err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_we, busy, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_we, busy, err
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Fetch/data bus sequencer in front of the 32x8 unified memory with registered read.
// Optional region checking is enabled by defining MEM_BUS_RANGE_CHECK_EN.
//
// state     | meaning
// IDLE      | sample requests, data port wins, latch address/wdata
// RD_ADDR   | address presented, memory registers read data at end of cycle
// RD_CAP    | memory drives bus, captured into requesting port's rdata
// WR        | mem_we=1, bus driven with store data
// ACK       | one-cycle ack (and err on rejection), requests ignored
module mem_bus_ctrl #(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int IMEM_TOP = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_bus_ctrl_if.slave bus,
  inout  wire  [DW-1:0] mem_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_CAP  = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;

  localparam logic [AW-1:0] L_IMEM_TOP = AW'(IMEM_TOP);

`ifdef MEM_BUS_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  logic [2:0]    r_state;
  logic          r_port_d;
  logic [DW-1:0] r_wdata;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_we;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_if_ack;
  logic          r_d_ack;
  logic          r_err;

  logic          w_any_req;
  logic          w_sel_d;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic          w_region_bad;
  logic          w_reject;

  assign w_any_req  = bus.d_req | bus.if_req;
  assign w_sel_d    = bus.d_req;
  assign w_sel_we   = bus.d_req & bus.d_we;
  assign w_sel_addr = w_sel_d ? bus.d_addr : bus.if_addr;

  // Fetches belong at or below IMEM_TOP, data accesses strictly above it.
  assign w_region_bad = w_sel_d ? (bus.d_addr <= L_IMEM_TOP) : (bus.if_addr > L_IMEM_TOP);
  assign w_reject     = RANGE_CHECK & w_region_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_port_d   <= 1'b0;
      r_wdata    <= '0;
      r_mem_addr <= '0;
      r_mem_we   <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_port_d <= w_sel_d;
            r_wdata  <= bus.d_wdata;
            if (w_reject) begin
              // No memory cycle: mem_addr and mem_we are left untouched.
              r_state  <= S_ACK;
              r_err    <= 1'b1;
              r_d_ack  <= w_sel_d;
              r_if_ack <= ~w_sel_d;
            end else begin
              r_mem_addr <= w_sel_addr;
              if (w_sel_we) begin
                r_mem_we <= 1'b1;
                r_state  <= S_WR;
              end else begin
                r_state <= S_RD_ADDR;
              end
            end
          end
        end
        S_RD_ADDR: r_state <= S_RD_CAP;
        S_RD_CAP: begin
          if (r_port_d) r_d_rdata  <= mem_data;
          else          r_if_rdata <= mem_data;
          r_d_ack  <= r_port_d;
          r_if_ack <= ~r_port_d;
          r_state  <= S_ACK;
        end
        S_WR: begin
          r_mem_we <= 1'b0;
          r_d_ack  <= 1'b1;
          r_state  <= S_ACK;
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus driven only in WR, so it can never fight the memory's read output.
  assign mem_data = (r_state == S_WR) ? r_wdata : {DW{1'bz}};

  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_we   = r_mem_we;
  assign bus.if_ack   = r_if_ack;
  assign bus.d_ack    = r_d_ack;
  assign bus.if_rdata = r_if_rdata;
  assign bus.d_rdata  = r_d_rdata;
  assign bus.err      = r_err;
  assign bus.busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a 32x8 registered-read memory model on the bus.
module tb_mem_bus_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_bus_ctrl_if #(.AW(5), .DW(8)) bus ();
  wire [7:0] mem_data;

  mem_bus_ctrl #(.AW(5), .DW(8), .IMEM_TOP(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_data (mem_data)
  );

  function automatic logic [7:0] init_val(input int i);
    if (i == 3) return 8'hA5;
    return 8'(i * 37 + 11);
  endfunction

  logic [7:0] mem [32];
  logic [7:0] mem_q;
  bit         mem_init_done = 1'b0;

  assign mem_data = bus.mem_we ? 8'bz : mem_q;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 32; i++) mem[i] = init_val(i);
      mem_init_done = 1'b1;
    end
    mem_q <= mem[bus.mem_addr];
    if (bus.mem_we) mem[bus.mem_addr] = mem_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input bit is_d, input bit we, input logic [4:0] addr,
                         input logic [7:0] wd, output int n, output bit saw_we,
                         output bit saw_err, output bit bus_bad);
    bit done;
    n = 0; saw_we = 0; saw_err = 0; bus_bad = 0; done = 0;
    @(posedge clk); #1;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      saw_we  |= bus.mem_we;
      saw_err |= bus.err;
      if (bus.mem_we ? (mem_data !== wd) : (mem_data !== mem_q)) bus_bad = 1;
      done = is_d ? bus.d_ack : bus.if_ack;
    end
    if (is_d) bus.d_req = 1'b0;
    else      bus.if_req = 1'b0;
  endtask

  int  n, nd, ni, last, k;
  bit  swe, serr, bbad, seen_d_ack;

  initial begin
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_we",   bus.mem_we,   0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_if_ack",   bus.if_ack,   0);
    check("rst_d_ack",    bus.d_ack,    0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_d_rdata",  bus.d_rdata,  0);
    check("rst_busy",     bus.busy,     0);
    check("rst_err",      bus.err,      0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset in the middle of a store
    @(posedge clk); #1;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 5'd9; bus.d_wdata = 8'hFF;
    @(posedge clk); #1;
    check("wr_mem_we",   bus.mem_we, 1);
    check("wr_busy",     bus.busy,   1);
    check("wr_bus_data", mem_data,   8'hFF);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mem_we", bus.mem_we, 0);
    check("midrst_busy",   bus.busy,   0);
    check("midrst_bus",    mem_data,   mem_q);
    bus.d_req = 0;
    seen_d_ack = 0;
    repeat (3) begin
      @(posedge clk); #1;
      seen_d_ack |= bus.d_ack;
    end
    #1 rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      seen_d_ack |= bus.d_ack;
    end
    check("midrst_no_ack", seen_d_ack, 0);

    // single fetch
    run_req(0, 0, 5'd3, 8'h00, n, swe, serr, bbad);
    check("fetch_lat",    n,            3);
    check("fetch_rdata",  bus.if_rdata, 8'hA5);
    check("fetch_no_we",  swe,          0);
    check("fetch_bus",    bbad,         0);
    check("fetch_d_rd",   bus.d_rdata,  0);
    @(posedge clk); #1;
    check("fetch_ack_1cy", bus.if_ack, 0);

    // store then load back
    run_req(1, 1, 5'd20, 8'h3C, n, swe, serr, bbad);
    check("store_lat", n,       2);
    check("store_we",  swe,     1);
    check("store_bus", bbad,    0);
    check("store_mem", mem[20], 8'h3C);
    check("store_we_off", bus.mem_we, 0);
    run_req(1, 0, 5'd20, 8'h00, n, swe, serr, bbad);
    check("load_lat",   n,            3);
    check("load_rdata", bus.d_rdata,  8'h3C);
    check("load_no_we", swe,          0);
    check("load_bus",   bbad,         0);
    check("load_if_rd", bus.if_rdata, 8'hA5);

    // simultaneous requests: data (store) first, then fetch
    @(posedge clk); #1;
    bus.if_req = 1; bus.if_addr = 5'd7;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 5'd22; bus.d_wdata = 8'h77;
    n = 0; nd = 0; ni = 0;
    while (ni == 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (bus.d_ack) begin nd = n; bus.d_req = 0; end
      if (bus.if_ack) begin ni = n; bus.if_req = 0; end
    end
    bus.if_req = 0; bus.d_req = 0;
    check("arb_d_lat",  nd,           2);
    check("arb_if_lat", ni,           6);
    check("arb_if_rd",  bus.if_rdata, init_val(7));
    check("arb_mem22",  mem[22],      8'h77);

    // back-to-back fetches 0..15
    @(posedge clk); #1;
    bus.if_req = 1; bus.if_addr = 5'd0;
    n = 0; last = 0; k = 0;
    while (k < 16 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus.if_ack) begin
        check("b2b_rdata", bus.if_rdata, init_val(k));
        check("b2b_gap",   n - last,     (k == 0) ? 3 : 4);
        last = n;
        k++;
        bus.if_addr = 5'(k);
      end
    end
    bus.if_req = 0;
    check("b2b_count", k, 16);

    // region checks
    run_req(0, 0, 5'd17, 8'h00, n, swe, serr, bbad);
`ifdef MEM_BUS_RANGE_CHECK_EN
    check("rc_fetch_lat",   n,            1);
    check("rc_fetch_err",   bus.err,      1);
    check("rc_fetch_rdata", bus.if_rdata, init_val(15));
    check("rc_fetch_no_we", swe,          0);
`else
    check("nc_fetch_lat",   n,            3);
    check("nc_fetch_err",   serr,         0);
    check("nc_fetch_rdata", bus.if_rdata, init_val(17));
`endif
    run_req(1, 1, 5'd2, 8'hEE, n, swe, serr, bbad);
`ifdef MEM_BUS_RANGE_CHECK_EN
    check("rc_store_lat",   n,      1);
    check("rc_store_err",   bus.err, 1);
    check("rc_store_no_we", swe,    0);
    check("rc_store_mem",   mem[2], init_val(2));
`else
    check("nc_store_lat", n,      2);
    check("nc_store_err", serr,   0);
    check("nc_store_mem", mem[2], 8'hEE);
`endif
    @(posedge clk); #1;
    check("end_err_low", bus.err,  0);
    check("end_idle",    bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
